// File: rtl/pd_header_loader.sv
// Write-side loader: turns a valid/ready byte stream into sequential storage byte writes (sel 0..TOTAL-1).
// Latency: each accepted byte is written one cycle later (registered); load_done pulses with the final write.
// Backpressure: rx_ready is high only in LOAD (and CHECK); no internal buffering, at most 1 byte/cycle.
//
// Ports:
//   clk, n_rst                   clock (rising edge), asynchronous active-low reset
//   start, abort                 begin a load (IDLE only) / cancel the load in progress
//   rx_data, rx_valid, rx_ready  incoming byte link
//   o_data_en, o_data, o_data_sel  storage write strobe, byte and byte select
//   load_busy, load_done, chk_err  status: in LOAD/CHECK, one-cycle completion pulse, checksum mismatch
//
// Optional feature: define LOADER_CHECKSUM_EN to take one extra trailing checksum byte
// (XOR of all stored bytes) and report a mismatch on chk_err. Without it chk_err is tied 0.
module pd_header_loader #(
    parameter int HEADER_BYTES = 80,
    parameter int DIFF_BYTES   = 4,
    parameter int SEL_W        = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             o_data_en,
    output logic [7:0]       o_data,
    output logic [SEL_W-1:0] o_data_sel,
    output logic             load_busy,
    output logic             load_done,
    output logic             chk_err
);

    localparam int               TOTAL = HEADER_BYTES + DIFF_BYTES;
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_cnt;
    logic             r_data_en;
    logic [7:0]       r_data;
    logic [SEL_W-1:0] r_data_sel;
    logic             w_busy;
    logic             w_acc;
    logic             w_last;
    logic             w_start_ok;

`ifdef LOADER_CHECKSUM_EN
    assign w_busy = (r_state == S_LOAD) || (r_state == S_CHECK);
`else
    assign w_busy = (r_state == S_LOAD);
`endif

    assign w_acc      = rx_valid && w_busy;
    assign w_last     = (r_cnt == LAST);
    // abort has priority over start in IDLE
    assign w_start_ok = (r_state == S_IDLE) && start && !abort;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_acc && w_last) begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_nxt = S_CHECK;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_acc) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte counter and registered storage write port.
    // The strobe defaults low each cycle, so only the cycle after an accepted,
    // non-aborted LOAD byte produces a write.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt      <= '0;
            r_data_en  <= 1'b0;
            r_data     <= '0;
            r_data_sel <= '0;
        end else begin
            r_data_en <= 1'b0;
            if (w_start_ok) begin
                r_cnt <= '0;
            end else if (r_state == S_LOAD) begin
                if (abort) begin
                    r_cnt <= '0;
                end else if (w_acc) begin
                    r_data_en  <= 1'b1;
                    r_data     <= rx_data;
                    r_data_sel <= r_cnt;
                    r_cnt      <= w_last ? '0 : r_cnt + SEL_W'(1);
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_xor;
    logic       r_chk_err;

    // Running XOR over stored bytes; the trailing byte taken in CHECK is compared
    // against it and never written. chk_err holds until the next accepted start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_xor     <= '0;
            r_chk_err <= 1'b0;
        end else if (w_start_ok) begin
            r_xor     <= '0;
            r_chk_err <= 1'b0;
        end else if ((r_state == S_LOAD) && w_acc && !abort) begin
            r_xor <= r_xor ^ rx_data;
        end else if ((r_state == S_CHECK) && w_acc && !abort) begin
            r_chk_err <= (rx_data != r_xor);
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

    assign rx_ready   = w_busy;
    assign load_busy  = w_busy;
    assign load_done  = (r_state == S_DONE);
    assign o_data_en  = r_data_en;
    assign o_data     = r_data;
    assign o_data_sel = r_data_sel;

endmodule

// File: tb/tb_pd_header_loader.sv
module tb_pd_header_loader;

    localparam int TOTAL = 84;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       o_data_en;
    logic [7:0] o_data;
    logic [6:0] o_data_sel;
    logic       load_busy;
    logic       load_done;
    logic       chk_err;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int exp_done = 0;

    logic [15:0] sb[$];          // expected writes {sel, data}
    logic [7:0]  mem [0:127];    // storage model fed by observed writes

    pd_header_loader #(.HEADER_BYTES(80), .DIFF_BYTES(4), .SEL_W(7)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .abort      (abort),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .o_data_en  (o_data_en),
        .o_data     (o_data),
        .o_data_sel (o_data_sel),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (n_rst) begin
            if (o_data_en) begin
                mem[o_data_sel] = o_data;
                if (sb.size() == 0) begin
                    chk("wr_unexpected", 32'(o_data_sel), 32'hFFFF);
                end else begin
                    logic [15:0] e;
                    e = sb.pop_front();
                    chk("wr_sel", 32'(o_data_sel), 32'(e[15:8]));
                    chk("wr_dat", 32'(o_data), 32'(e[7:0]));
                end
            end
            if (load_done) n_done++;
        end
    end

    task automatic start_load();
        chk("idle_rdy", 32'(rx_ready), 0);
        start = 1'b1;
        abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", 32'(load_busy), 1);
        chk("start_chk_clr", 32'(chk_err), 0);
    endtask

    // One full load of bytes 0..TOTAL-1 (data = sel); optional gaps and a stray start.
    task automatic do_load(input bit gapped, input int start_at, input logic [7:0] csum);
        logic [7:0] x;
        logic       exp_err;
        x = 8'h00;
        start_load();
        for (int i = 0; i < TOTAL; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            start    = (i == start_at);
            x        = x ^ 8'(i);
            chk("ld_rdy", 32'(rx_ready), 1);
            sb.push_back({8'(i), 8'(i)});
            @(posedge clk); #1;
            start = 1'b0;
            if (gapped && i < TOTAL - 1) begin
                rx_valid = 1'b0;
                chk("gap_rdy", 32'(rx_ready), 1);
                @(posedge clk); #1;
            end
        end
        exp_err = CS_EN && (csum != x);
`ifdef LOADER_CHECKSUM_EN
        chk("cs_rdy", 32'(rx_ready), 1);
        chk("cs_busy", 32'(load_busy), 1);
        rx_valid = 1'b1;
        rx_data  = csum;
        @(posedge clk); #1;
`else
        chk("done_wr_en", 32'(o_data_en), 1);
        chk("done_wr_sel", 32'(o_data_sel), TOTAL - 1);
`endif
        rx_valid = 1'b0;
        chk("done_pulse", 32'(load_done), 1);
        chk("done_rdy", 32'(rx_ready), 0);
        chk("done_busy", 32'(load_busy), 0);
        chk("done_chk_err", 32'(chk_err), 32'(exp_err));
        @(posedge clk); #1;
        exp_done++;
        chk("done_one_cycle", 32'(load_done), 0);
        chk("sb_empty", sb.size(), 0);
        chk("done_count", n_done, exp_done);
        chk("err_hold", 32'(chk_err), 32'(exp_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'hEE;

        // Reset state
        #12;
        chk("rst_rdy", 32'(rx_ready), 0);
        chk("rst_en", 32'(o_data_en), 0);
        chk("rst_busy", 32'(load_busy), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_err", 32'(chk_err), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a load at cnt=37
        start_load();
        for (int i = 0; i < 37; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            sb.push_back({8'(i), 8'(i)});
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        @(negedge clk); #1;
        chk("pre_rst_sel", 32'(o_data_sel), 36);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(rx_ready), 0);
        chk("mid_rst_en", 32'(o_data_en), 0);
        chk("mid_rst_sel", 32'(o_data_sel), 0);
        chk("mid_rst_dat", 32'(o_data), 0);
        chk("mid_rst_busy", 32'(load_busy), 0);
        chk("mid_rst_done", 32'(load_done), 0);
        chk("mid_rst_sb", sb.size(), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_nodone", n_done, exp_done);

        // Full load with rx_valid held high; restarts at sel 0
        do_load(1'b0, -1, 8'h00);
        chk("mem_diff", {mem[83], mem[82], mem[81], mem[80]}, 32'h53525150);
        chk("mem_c1_0", 32'(mem[0]), 0);
        chk("mem_c1_63", 32'(mem[63]), 63);
        chk("mem_c2_0", 32'(mem[64]), 64);
        chk("mem_c2_15", 32'(mem[79]), 79);

        // Gapped stream, back to back with the previous load
        do_load(1'b1, -1, 8'h00);

        // Stray start at cnt=10 is ignored
        do_load(1'b0, 10, 8'h00);

        // Abort at cnt=40 with a byte offered in the same cycle
        start_load();
        for (int i = 0; i < 40; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            sb.push_back({8'(i), 8'(i)});
            @(posedge clk); #1;
        end
        rx_data = 8'd40;
        abort   = 1'b1;
        @(posedge clk); #1;
        abort    = 1'b0;
        rx_valid = 1'b0;
        chk("abort_rdy", 32'(rx_ready), 0);
        chk("abort_busy", 32'(load_busy), 0);
        chk("abort_no_wr", 32'(o_data_en), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_sb", sb.size(), 0);
        chk("abort_nodone", n_done, exp_done);

        // start and abort together in IDLE: stay IDLE
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(load_busy), 0);
        chk("sa_rdy", 32'(rx_ready), 0);
        @(posedge clk); #1;
        chk("sa_busy2", 32'(load_busy), 0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum, then a good one clears it at start
        do_load(1'b0, -1, 8'hFF);
        @(posedge clk); #1;
        chk("cs_err_hold", 32'(chk_err), 1);
        do_load(1'b0, -1, 8'h00);
`else
        // Recovery after abort
        do_load(1'b0, -1, 8'h00);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("final_sb", sb.size(), 0);
        chk("final_done", n_done, exp_done);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
